control_sequencer_module: RTL and testbench
===========================================

Name: control_sequencer_module

Overview:
- Micro-sequencer for the ASAP-1 8-bit bus machine.
- Steps through fetch and execute T-states and drives every register's ie/oe, the PC step and the ALU controls, so exactly one source owns the shared bus per cycle.
- Takes the instruction register's opcode nibble and the flags register.
- Sits beside the register/counter modules and is the sole owner of their control inputs.

Parameters:
- OPCODE_W, 4, opcode width taken from IR[7:4].
- STATE_W, 3, T-state counter width; holds T0..T4 plus HALTED.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset.
- run  input  1  1 = advance one T-state per clock; 0 = freeze.
- opcode  input  4  IR upper nibble.
- carry  input  1  carry flag; used only with COND_JUMP_EN.
- zero  input  1  zero flag; used only with COND_JUMP_EN.
- pc_oe, pc_ie, pc_step  output  1 each  program counter controls.
- mar_ie  output  1  memory address register load.
- ram_oe, ram_ie  output  1 each  RAM read onto bus / write from bus.
- ir_ie, ir_oe  output  1 each  IR load / IR low nibble onto bus.
- a_ie, a_oe, b_ie  output  1 each  A and B register controls.
- alu_oe, alu_sub, flags_ie  output  1 each  ALU result onto bus, subtract select, flag capture.
- out_ie  output  1  output register load.
- t_state  output  3  current T-state, for the debug display.
- halted  output  1  sticky halt indicator.

Behaviour:
- Reset: rst low forces t_state=T0 and halted=0, and all control outputs to 0, asynchronously.
- Outputs: a combinational decode of registered state (t_state, opcode, flags).
- Run gating: run=0 holds state and forces all control outputs to 0. It may be deasserted mid-instruction; the instruction resumes at the held T-state.
- Fetch, common to all opcodes:
  - T0: pc_oe, mar_ie.
  - T1: ram_oe, ir_ie, pc_step.
- Execute by opcode:
  - NOP 0000: T2 none.
  - LDA 0001: T2 ir_oe+mar_ie; T3 ram_oe+a_ie.
  - ADD 0010: T2 ir_oe+mar_ie; T3 ram_oe+b_ie; T4 alu_oe+a_ie+flags_ie.
  - SUB 0011: as ADD, with alu_sub also asserted in T3 and T4.
  - STA 0100: T2 ir_oe+mar_ie; T3 a_oe+ram_ie.
  - LDI 0101: T2 ir_oe+a_ie.
  - JMP 0110: T2 ir_oe+pc_ie.
  - OUT 1110: T2 a_oe+out_ie.
  - HLT 1111: T2 no outputs; next state HALTED.
  - Undefined opcodes: treated as NOP.
- Early termination: after an instruction's last micro-step, next state is T0. Cycle counts: NOP/LDI/JMP/OUT = 3, LDA/STA = 4, ADD/SUB = 5.
- HALTED: all outputs 0, halted=1, and run is ignored; exit only via rst.
- Invariant: at most one of pc_oe, ram_oe, ir_oe, a_oe, alu_oe is high in any cycle.
- Invariant: pc_step and pc_ie are never high together.
- Opcode changes: opcode is sampled only through the decode, so a change during T0/T1 does not disturb fetch. IR loads at the end of T1, so the T2 decode uses the new opcode.

Optional Feature:
- Macro: CONTROL_SEQUENCER_COND_JUMP_EN.
- Defined:
  - JC 0111: T2 ir_oe+pc_ie if carry=1, else no outputs.
  - JZ 1000: T2 ir_oe+pc_ie if zero=1, else no outputs.
  - Both take 3 cycles. Flags are sampled combinationally during T2.
- Undefined: 0111/1000 execute as NOP, and the carry/zero ports are present but unused.

Decomposition:
- global.vh holds:
  - opcode localparams;
  - T-state encodings (T0..T4, HALTED);
  - control-word bit indices;
  - the TRUE/FALSE constants.
- One natural sub-module: microcode_decode_module, purely combinational, mapping (t_state, opcode, carry, zero) to the control word plus a last-step flag.
- The top of control_sequencer_module keeps only the state register, halt logic, run gating and output breakout.

Test Plan:
- Reset/run: rst low mid-T3 of ADD → t_state=0 and all controls 0 immediately. Release with run=1 → T0 shows pc_oe=1, mar_ie=1.
- ADD: opcode=0010 → T0, T1, T2, T3, T4, T0. At T4, alu_oe=a_ie=flags_ie=1 and alu_sub=0. Repeat with SUB 0011 → alu_sub=1 in T3 and T4.
- Early termination: LDI 0101 → T2 asserts ir_oe+a_ie, next cycle t_state=0. Undefined opcode 1010 → 3-cycle NOP with no T2 outputs.
- Halt: HLT 1111 → after T2, halted=1 and outputs 0 for 20 cycles with run=1. Then rst pulse → halted=0, t_state=0.
- Freeze: drop run at T1 of LDA for 5 cycles → t_state stays 1 and outputs 0. Restore run → ram_oe+ir_ie+pc_step, then completion in 3 more cycles.
- Conditional jump (feature on): JZ with zero=1 → pc_ie=1 at T2; with zero=0 → no outputs. Feature off → NOP.
- All tests: a bus-contention assertion checks the one-oe invariant on every cycle.

Source files
------------

// File: rtl/control_sequencer_module_pkg.sv
// Shared encodings for the ASAP-1 micro-sequencer: opcodes, T-states and control-word layout.
package control_sequencer_module_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] T0     = 3'd0;
  localparam logic [2:0] T1     = 3'd1;
  localparam logic [2:0] T2     = 3'd2;
  localparam logic [2:0] T3     = 3'd3;
  localparam logic [2:0] T4     = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;

  localparam int CW_PC_OE    = 0;
  localparam int CW_PC_IE    = 1;
  localparam int CW_PC_STEP  = 2;
  localparam int CW_MAR_IE   = 3;
  localparam int CW_RAM_OE   = 4;
  localparam int CW_RAM_IE   = 5;
  localparam int CW_IR_IE    = 6;
  localparam int CW_IR_OE    = 7;
  localparam int CW_A_IE     = 8;
  localparam int CW_A_OE     = 9;
  localparam int CW_B_IE     = 10;
  localparam int CW_ALU_OE   = 11;
  localparam int CW_ALU_SUB  = 12;
  localparam int CW_FLAGS_IE = 13;
  localparam int CW_OUT_IE   = 14;
  localparam int CW_W        = 15;

  typedef logic [CW_W-1:0] ctrl_word_t;

  function automatic ctrl_word_t cw_bit(input int idx);
    return ctrl_word_t'(1) << idx;
  endfunction

endpackage

// File: rtl/control_sequencer_module_if.sv
// Sequencer-side bundle: status in (run, opcode, flags) and every register/ALU control out.
interface control_sequencer_module_if #(
  parameter int OPCODE_W = 4,
  parameter int STATE_W  = 3
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                carry;
  logic                zero;
  logic                pc_oe, pc_ie, pc_step;
  logic                mar_ie;
  logic                ram_oe, ram_ie;
  logic                ir_ie, ir_oe;
  logic                a_ie, a_oe, b_ie;
  logic                alu_oe, alu_sub, flags_ie;
  logic                out_ie;
  logic [STATE_W-1:0]  t_state;
  logic                halted;

  modport master (
    input  run, opcode, carry, zero,
    output pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie, t_state, halted
  );

  modport slave (
    output run, opcode, carry, zero,
    input  pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
           a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie, t_state, halted
  );
endinterface

// File: rtl/control_sequencer_module_microcode_decode.sv
// Combinational microcode ROM: (T-state, opcode, flags) -> control word and last-step flag.
// Conditional jumps JC/JZ exist only when CONTROL_SEQUENCER_COND_JUMP_EN is defined.
module microcode_decode_module
  import control_sequencer_module_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [2:0]          t_state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry,
  input  logic                zero,
  output ctrl_word_t          cw,
  output logic                last_step
);

`ifndef CONTROL_SEQUENCER_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = carry ^ zero;
`endif

  always_comb begin
    cw        = '0;
    last_step = FALSE;
    case (t_state)
      T0: cw = cw_bit(CW_PC_OE) | cw_bit(CW_MAR_IE);
      T1: cw = cw_bit(CW_RAM_OE) | cw_bit(CW_IR_IE) | cw_bit(CW_PC_STEP);
      T2: begin
        // Memory-operand instructions continue past T2; everything else ends here.
        last_step = TRUE;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw        = cw_bit(CW_IR_OE) | cw_bit(CW_MAR_IE);
            last_step = FALSE;
          end
          OP_LDI: cw = cw_bit(CW_IR_OE) | cw_bit(CW_A_IE);
          OP_JMP: cw = cw_bit(CW_IR_OE) | cw_bit(CW_PC_IE);
`ifdef CONTROL_SEQUENCER_COND_JUMP_EN
          OP_JC: if (carry) cw = cw_bit(CW_IR_OE) | cw_bit(CW_PC_IE);
          OP_JZ: if (zero)  cw = cw_bit(CW_IR_OE) | cw_bit(CW_PC_IE);
`endif
          OP_OUT: cw = cw_bit(CW_A_OE) | cw_bit(CW_OUT_IE);
          default: cw = '0;
        endcase
      end
      T3: begin
        last_step = TRUE;
        case (opcode)
          OP_LDA: cw = cw_bit(CW_RAM_OE) | cw_bit(CW_A_IE);
          OP_ADD: begin
            cw        = cw_bit(CW_RAM_OE) | cw_bit(CW_B_IE);
            last_step = FALSE;
          end
          OP_SUB: begin
            cw        = cw_bit(CW_RAM_OE) | cw_bit(CW_B_IE) | cw_bit(CW_ALU_SUB);
            last_step = FALSE;
          end
          OP_STA: cw = cw_bit(CW_A_OE) | cw_bit(CW_RAM_IE);
          default: cw = '0;
        endcase
      end
      T4: begin
        last_step = TRUE;
        case (opcode)
          OP_ADD: cw = cw_bit(CW_ALU_OE) | cw_bit(CW_A_IE) | cw_bit(CW_FLAGS_IE);
          OP_SUB: cw = cw_bit(CW_ALU_OE) | cw_bit(CW_A_IE) | cw_bit(CW_FLAGS_IE)
                     | cw_bit(CW_ALU_SUB);
          default: cw = '0;
        endcase
      end
      default: last_step = TRUE;
    endcase
  end

endmodule

// File: rtl/control_sequencer_module.sv
// ASAP-1 micro-sequencer top: T-state register, halt latch, run gating and control breakout.
// Optional JC/JZ support via CONTROL_SEQUENCER_COND_JUMP_EN (passed through to the decoder).
module control_sequencer_module
  import control_sequencer_module_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STATE_W  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  control_sequencer_module_if.master   bus
);

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [OPCODE_W-1:0] opcode;
  ctrl_word_t          cw_raw;
  ctrl_word_t          cw;
  logic                last_step;
  logic                active;

  assign opcode = bus.opcode;

  microcode_decode_module #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .t_state   (state),
    .opcode    (opcode),
    .carry     (bus.carry),
    .zero      (bus.zero),
    .cw        (cw_raw),
    .last_step (last_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= T0;
    else      state <= state_nxt;
  end

  // HALTED is absorbing and ignores run; only reset leaves it.
  always_comb begin
    state_nxt = state;
    if (state != HALTED && bus.run) begin
      if (state == T2 && opcode == OP_HLT) state_nxt = HALTED;
      else if (last_step)                  state_nxt = T0;
      else                                 state_nxt = state + 3'd1;
    end
  end

  // Gating on rst keeps every control low while reset is asserted, even though T0 decodes non-zero.
  assign active = rst && bus.run && (state != HALTED);

  always_comb begin
    cw = '0;
    if (active) cw = cw_raw;
  end

  assign bus.pc_oe    = cw[CW_PC_OE];
  assign bus.pc_ie    = cw[CW_PC_IE];
  assign bus.pc_step  = cw[CW_PC_STEP];
  assign bus.mar_ie   = cw[CW_MAR_IE];
  assign bus.ram_oe   = cw[CW_RAM_OE];
  assign bus.ram_ie   = cw[CW_RAM_IE];
  assign bus.ir_ie    = cw[CW_IR_IE];
  assign bus.ir_oe    = cw[CW_IR_OE];
  assign bus.a_ie     = cw[CW_A_IE];
  assign bus.a_oe     = cw[CW_A_OE];
  assign bus.b_ie     = cw[CW_B_IE];
  assign bus.alu_oe   = cw[CW_ALU_OE];
  assign bus.alu_sub  = cw[CW_ALU_SUB];
  assign bus.flags_ie = cw[CW_FLAGS_IE];
  assign bus.out_ie   = cw[CW_OUT_IE];
  assign bus.t_state  = STATE_W'(state);
  assign bus.halted   = (state == HALTED);

endmodule

// File: tb/tb_control_sequencer_module.sv
// Bench for control_sequencer_module: instruction-level model plus directed checks.
module tb_control_sequencer_module;

  typedef struct packed {
    logic pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe;
    logic a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_sequencer_module_if bus ();

  control_sequencer_module dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miss    = 0;

  ctl_t act;
  assign act = {bus.pc_oe, bus.pc_ie, bus.pc_step, bus.mar_ie, bus.ram_oe, bus.ram_ie,
                bus.ir_ie, bus.ir_oe, bus.a_ie, bus.a_oe, bus.b_ie, bus.alu_oe,
                bus.alu_sub, bus.flags_ie, bus.out_ie};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, a, e, $time);
    end
  endtask

  // Instruction length in clocks, from the opcode table.
  function automatic int spec_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Micro-step table: which controls each step of each instruction asserts.
  function automatic ctl_t spec_ctl(input int step, input logic [3:0] op, input logic c, input logic z);
    ctl_t r = '0;
    if (step == 0) begin
      r.pc_oe = 1; r.mar_ie = 1;
    end else if (step == 1) begin
      r.ram_oe = 1; r.ir_ie = 1; r.pc_step = 1;
    end else begin
      case (op)
        4'h1: if (step == 2) begin r.ir_oe = 1; r.mar_ie = 1; end
              else if (step == 3) begin r.ram_oe = 1; r.a_ie = 1; end
        4'h2, 4'h3: begin
          if (step == 2) begin r.ir_oe = 1; r.mar_ie = 1; end
          else if (step == 3) begin r.ram_oe = 1; r.b_ie = 1; r.alu_sub = (op == 4'h3); end
          else if (step == 4) begin
            r.alu_oe = 1; r.a_ie = 1; r.flags_ie = 1; r.alu_sub = (op == 4'h3);
          end
        end
        4'h4: if (step == 2) begin r.ir_oe = 1; r.mar_ie = 1; end
              else if (step == 3) begin r.a_oe = 1; r.ram_ie = 1; end
        4'h5: if (step == 2) begin r.ir_oe = 1; r.a_ie = 1; end
        4'h6: if (step == 2) begin r.ir_oe = 1; r.pc_ie = 1; end
`ifdef CONTROL_SEQUENCER_COND_JUMP_EN
        4'h7: if (step == 2 && c) begin r.ir_oe = 1; r.pc_ie = 1; end
        4'h8: if (step == 2 && z) begin r.ir_oe = 1; r.pc_ie = 1; end
`endif
        4'hE: if (step == 2) begin r.a_oe = 1; r.out_ie = 1; end
        default: r = '0;
      endcase
    end
    if (c === 1'bx || z === 1'bx) r = 'x;
    return r;
  endfunction

  int   m_step;
  logic m_halted;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_step   <= 0;
      m_halted <= 1'b0;
    end else if (!m_halted && bus.run) begin
      if (m_step == 2 && bus.opcode == 4'hF) m_halted <= 1'b1;
      else if (m_step + 1 >= spec_len(bus.opcode)) m_step <= 0;
      else m_step <= m_step + 1;
    end
  end

  always @(negedge clk) begin
    ctl_t e;
    int   oe_cnt;
    e = '0;
    if (rst && bus.run && !m_halted) e = spec_ctl(m_step, bus.opcode, bus.carry, bus.zero);
    chk("model_ctl", 32'(act), 32'(e));
    chk("model_halted", 32'(bus.halted), 32'(m_halted));
    if (!m_halted) chk("model_t_state", 32'(bus.t_state), 32'(m_step));
    oe_cnt = int'(bus.pc_oe) + int'(bus.ram_oe) + int'(bus.ir_oe) + int'(bus.a_oe) + int'(bus.alu_oe);
    chk("one_oe", 32'(oe_cnt <= 1), 32'd1);
    chk("pc_step_vs_ie", 32'(bus.pc_step & bus.pc_ie), 32'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before t=100000");
    $fatal(1, "watchdog");
  end

  logic [3:0] sweep_op  [7];
  int         sweep_len [7];
  logic       jz_exp;

  initial begin
    sweep_op  = '{4'h0, 4'h4, 4'h6, 4'hE, 4'h7, 4'h8, 4'h1};
    sweep_len = '{3, 4, 3, 3, 3, 3, 4};
`ifdef CONTROL_SEQUENCER_COND_JUMP_EN
    jz_exp = 1'b1;
`else
    jz_exp = 1'b0;
`endif
    rst = 1'b0; bus.run = 1'b0; bus.opcode = 4'h0; bus.carry = 1'b0; bus.zero = 1'b0;
    #12;
    chk("reset_t_state", 32'(bus.t_state), 0);
    chk("reset_ctl", 32'(act), 0);
    chk("reset_halted", 32'(bus.halted), 0);

    // ADD interrupted by an asynchronous reset in T3
    bus.opcode = 4'b0010; bus.run = 1'b1; rst = 1'b1;
    #1;
    chk("rel_t0_pc_oe", 32'(bus.pc_oe), 1);
    chk("rel_t0_mar_ie", 32'(bus.mar_ie), 1);
    cycn(3);
    chk("add_t3_state", 32'(bus.t_state), 3);
    chk("add_t3_b_ie", 32'(bus.b_ie), 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_state", 32'(bus.t_state), 0);
    chk("rst_async_ctl", 32'(act), 0);
    rst = 1'b1;

    // Full ADD then SUB
    cycn(4);
    chk("add_t4_state", 32'(bus.t_state), 4);
    chk("add_t4_alu_oe", 32'(bus.alu_oe), 1);
    chk("add_t4_a_ie", 32'(bus.a_ie), 1);
    chk("add_t4_flags_ie", 32'(bus.flags_ie), 1);
    chk("add_t4_alu_sub", 32'(bus.alu_sub), 0);
    cyc();
    chk("add_wrap", 32'(bus.t_state), 0);
    bus.opcode = 4'b0011;
    cycn(3);
    chk("sub_t3_alu_sub", 32'(bus.alu_sub), 1);
    cyc();
    chk("sub_t4_alu_sub", 32'(bus.alu_sub), 1);
    chk("sub_t4_alu_oe", 32'(bus.alu_oe), 1);
    cyc();
    chk("sub_wrap", 32'(bus.t_state), 0);

    // Opcode change during fetch, then LDI
    bus.opcode = 4'hF;
    cyc();
    bus.opcode = 4'b0101;
    cyc();
    chk("ldi_t2_ir_oe", 32'(bus.ir_oe), 1);
    chk("ldi_t2_a_ie", 32'(bus.a_ie), 1);
    chk("ldi_t2_halted", 32'(bus.halted), 0);
    cyc();
    chk("ldi_wrap", 32'(bus.t_state), 0);

    // Undefined opcode behaves as NOP
    bus.opcode = 4'b1010;
    cycn(2);
    chk("undef_t2_ctl", 32'(act), 0);
    cyc();
    chk("undef_wrap", 32'(bus.t_state), 0);

    // Remaining opcodes: cycle counts
    for (int k = 0; k < 7; k++) begin
      bus.opcode = sweep_op[k];
      cycn(sweep_len[k]);
      chk($sformatf("len_op%0h", sweep_op[k]), 32'(bus.t_state), 0);
    end

    // Freeze LDA at T1
    bus.opcode = 4'b0001;
    cyc();
    bus.run = 1'b0;
    #1;
    chk("frz_state", 32'(bus.t_state), 1);
    chk("frz_ctl", 32'(act), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("frz_hold_state", 32'(bus.t_state), 1);
      chk("frz_hold_ctl", 32'(act), 0);
    end
    bus.run = 1'b1;
    #1;
    chk("frz_resume_ram_oe", 32'(bus.ram_oe), 1);
    chk("frz_resume_ir_ie", 32'(bus.ir_ie), 1);
    chk("frz_resume_pc_step", 32'(bus.pc_step), 1);
    cycn(3);
    chk("frz_done", 32'(bus.t_state), 0);

    // Conditional jumps
    bus.opcode = 4'b1000; bus.zero = 1'b1;
    cycn(2);
    chk("jz_taken_pc_ie", 32'(bus.pc_ie), 32'(jz_exp));
    chk("jz_taken_ir_oe", 32'(bus.ir_oe), 32'(jz_exp));
    cyc();
    bus.zero = 1'b0;
    cycn(2);
    chk("jz_not_taken_ctl", 32'(act), 0);
    cyc();
    bus.opcode = 4'b0111; bus.carry = 1'b1;
    cycn(2);
    chk("jc_taken_pc_ie", 32'(bus.pc_ie), 32'(jz_exp));
    cyc();
    bus.carry = 1'b0;

    // Halt, then leave by reset
    bus.opcode = 4'hF;
    cycn(2);
    chk("hlt_t2_ctl", 32'(act), 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("hlt_halted", 32'(bus.halted), 1);
      chk("hlt_ctl", 32'(act), 0);
    end
    #1 rst = 1'b0;
    #1;
    chk("hlt_rst_halted", 32'(bus.halted), 0);
    chk("hlt_rst_state", 32'(bus.t_state), 0);
    rst = 1'b1;
    bus.opcode = 4'h0;
    cyc();
    chk("post_hlt_run", 32'(bus.t_state), 1);
    cycn(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
